// File: rtl/hex_bank_control_pkg.sv
// Shared constants for the seven-segment bank: segment table, blank code and
// register bit layout.
package hex_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments {g,f,e,d,c,b,a}, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam int DIG_VALUE_LSB     = 0;
  localparam int DIG_VALUE_MSB     = 3;
  localparam int DIG_BLANK_BIT     = 4;
  localparam int DIG_BLINK_BIT     = 5;
  localparam int DIG_WIDTH         = 6;
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_WIDTH        = 2;

  typedef struct packed {
    logic       blink;
    logic       blank;
    logic [3:0] value;
  } digit_t;

  typedef struct packed {
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam digit_t DIGIT_RESET = '{blink: 1'b0, blank: 1'b1, value: 4'h0};
  localparam ctrl_t  CTRL_RESET  = '{blink_en: 1'b0, enable: 1'b1};

endpackage

// File: rtl/hex_bank_control_if.sv
// Register-bus bundle between a host and the seven-segment bank.
interface hex_bank_control_if #(
  parameter int AW = 3
);
  logic          iChip_select_n;
  logic          iWrite_n;
  logic          iRead_n;
  logic [AW-1:0] iAddress;
  logic [7:0]    iWrite_data;
  logic [7:0]    oRead_data;

  modport master (
    output iChip_select_n, iWrite_n, iRead_n, iAddress, iWrite_data,
    input  oRead_data
  );

  modport slave (
    input  iChip_select_n, iWrite_n, iRead_n, iAddress, iWrite_data,
    output oRead_data
  );
endinterface

// File: rtl/hex_bank_control_seg_decoder.sv
// Combinational hex-to-seven-segment lookup, one instance per digit.
module hex_seg_decoder
  import hex_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[value_i];
endmodule

// File: rtl/hex_bank_control.sv
// Register-mapped bank of seven-segment digits with per-digit blank/blink
// and a global enable; display and read data are registered.
module hex_bank_control
  import hex_pkg::*;
#(
  parameter  int NUM_DIGITS = 6,
  parameter  int BLINK_DIV  = 25000000,
  localparam int AW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    iClk,
  input  logic                    iReset,
  hex_bank_control_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] oHex_Display
);

  localparam int CW = $clog2(BLINK_DIV);

  digit_t                  digit_q [NUM_DIGITS];
  digit_t                  digit_d [NUM_DIGITS];
  ctrl_t                   ctrl_q, ctrl_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [7*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [6:0]              seg_w [NUM_DIGITS];

  logic          wr_en, rd_en;
  logic [AW-1:0] addr;
  logic          unused_wdata;

  assign addr         = bus.iAddress;
  assign wr_en        = !bus.iChip_select_n && !bus.iWrite_n;
  // A cycle with both strobes low is a write; the read side stays idle.
  assign rd_en        = !bus.iChip_select_n && !bus.iRead_n && bus.iWrite_n;
  assign unused_wdata = ^bus.iWrite_data[7:DIG_WIDTH];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (
      .value_i (digit_q[g].value),
      .seg_o   (seg_w[g])
    );
  end

  // Register file: writes and reads.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;

    if (wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (addr == AW'(k)) begin
          digit_d[k] = digit_t'(bus.iWrite_data[DIG_WIDTH-1:0]);
        end
      end
      if (addr == AW'(NUM_DIGITS)) begin
        ctrl_d = ctrl_t'(bus.iWrite_data[CTRL_WIDTH-1:0]);
      end
    end

    if (rd_en) begin
      rdata_d = 8'h00;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (addr == AW'(k)) begin
          rdata_d = {{(8-DIG_WIDTH){1'b0}}, digit_q[k]};
        end
      end
      if (addr == AW'(NUM_DIGITS)) begin
        rdata_d = {{(8-CTRL_WIDTH){1'b0}}, ctrl_q};
      end
    end
  end

  // Blink timebase: cleared on the same edge that blink_en drops, and only
  // starts counting once blink_en is already set.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!ctrl_d.blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (ctrl_q.blink_en) begin
      if (cnt_q == CW'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Segment output: suppressed by global disable, per-digit blank, or the
  // off half of the blink period.
  always_comb begin
    disp_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!ctrl_q.enable || digit_q[k].blank ||
          (digit_q[k].blink && ctrl_q.blink_en && phase_q)) begin
        disp_d[7*k +: 7] = SEG_BLANK;
      end else begin
        disp_d[7*k +: 7] = seg_w[k];
      end
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (iReset) begin
      // NOTE: the digit array is a handful of flops, not a RAM, so each entry
      // is reset explicitly to a known blanked state.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= DIGIT_RESET;
      end
      ctrl_q  <= CTRL_RESET;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rdata_q <= 8'h00;
      disp_q  <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      digit_q <= digit_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rdata_q <= rdata_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.oRead_data = rdata_q;
  assign oHex_Display   = disp_q;

endmodule

// File: tb/tb_hex_bank_control.sv
// Self-checking bench for hex_bank_control: register tables, display and
// blink timing, reset mid-blink.
module tb_hex_bank_control;

  localparam int ND  = 6;
  localparam int DIV = 4;
  localparam int AW  = $clog2(ND + 1);
  localparam logic [7*ND-1:0] ALL_OFF = {(7*ND){1'b1}};

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7*ND-1:0] hex;

  int checks = 0;
  int errors = 0;

  logic [5:0] m_digit [ND];
  logic       m_en;
  logic       m_ben;
  logic [7:0] rd_q [$];
  vec_t       tbl [$];

  hex_bank_control_if #(.AW(AW)) bus ();

  hex_bank_control #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
    .iClk         (clk),
    .iReset       (rst),
    .bus          (bus),
    .oHex_Display (hex)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'b1000000;  4'h1: ref_seg = 7'b1111001;
      4'h2: ref_seg = 7'b0100100;  4'h3: ref_seg = 7'b0110000;
      4'h4: ref_seg = 7'b0011001;  4'h5: ref_seg = 7'b0010010;
      4'h6: ref_seg = 7'b0000010;  4'h7: ref_seg = 7'b1111000;
      4'h8: ref_seg = 7'b0000000;  4'h9: ref_seg = 7'b0010000;
      4'hA: ref_seg = 7'b0001000;  4'hB: ref_seg = 7'b0000011;
      4'hC: ref_seg = 7'b1000110;  4'hD: ref_seg = 7'b0100001;
      4'hE: ref_seg = 7'b0000110;  default: ref_seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] exp_disp(input logic ph);
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) begin
      if (!m_en || m_digit[k][4] || (m_digit[k][5] && m_ben && ph))
        r[7*k +: 7] = 7'b1111111;
      else
        r[7*k +: 7] = ref_seg(m_digit[k][3:0]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) m_digit[k] = 6'h10;
    m_en  = 1'b1;
    m_ben = 1'b0;
  endtask

  // One bus cycle: drive at negedge, returns 1 time unit after the edge.
  task automatic bus_cycle(input logic wr, input logic rd, input logic [AW-1:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    bus.iChip_select_n = !(wr || rd);
    bus.iWrite_n       = !wr;
    bus.iRead_n        = !rd;
    bus.iAddress       = a;
    bus.iWrite_data    = d;
    @(posedge clk);
    #1;
    bus.iChip_select_n = 1'b1;
    bus.iWrite_n       = 1'b1;
    bus.iRead_n        = 1'b1;
    if (wr) begin
      if (int'(a) < ND) m_digit[a] = d[5:0];
      else if (int'(a) == ND) begin
        m_en  = d[0];
        m_ben = d[1];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      rd_q.push_back(tbl[i].exp_rd);
      bus_cycle(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      check($sformatf("%s_row%0d_rdata", tag, i), bus.oRead_data, rd_q.pop_front());
    end
    tbl.delete();
  endtask

  task automatic load_reset_table();
    for (int k = 0; k < ND; k++) tbl.push_back('{1'b0, 1'b1, AW'(k), 8'h00, 8'h10});
    tbl.push_back('{1'b0, 1'b1, AW'(ND), 8'h00, 8'h01});
  endtask

  task automatic blink_run(input string tag, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      idle(1);
      check($sformatf("%s_k%0d", tag, k), hex, exp_disp(1'(((k - 1) / DIV) % 2)));
    end
  endtask

  initial begin
    bus.iChip_select_n = 1'b1;
    bus.iWrite_n       = 1'b1;
    bus.iRead_n        = 1'b1;
    bus.iAddress       = '0;
    bus.iWrite_data    = 8'h00;
    model_reset();

    // Reset state
    idle(3);
    check("reset_disp", hex, ALL_OFF);
    check("reset_rdata", bus.oRead_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    load_reset_table();
    run_table("reset_read");
    check("reset_disp_after_reads", hex, ALL_OFF);

    // Single digit write and its display latency
    bus_cycle(1'b1, 1'b0, AW'(2), 8'h0A);
    check("wr_latency_disp", hex, ALL_OFF);
    idle(1);
    check("digit2_disp", hex, {{(3*7){1'b1}}, 7'b0001000, {(2*7){1'b1}}});
    check("digit2_model", hex, exp_disp(1'b0));

    // Register map corners: out-of-range, read+write, dropped bits
    tbl.push_back('{1'b0, 1'b1, AW'(2),      8'h00, 8'h0A});
    tbl.push_back('{1'b1, 1'b0, AW'(ND + 1), 8'hFF, 8'h0A});
    tbl.push_back('{1'b0, 1'b1, AW'(ND + 1), 8'h00, 8'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(ND),     8'h00, 8'h01});
    tbl.push_back('{1'b0, 1'b1, AW'(2),      8'h00, 8'h0A});
    tbl.push_back('{1'b1, 1'b1, AW'(1),      8'h15, 8'h0A});
    tbl.push_back('{1'b0, 1'b1, AW'(1),      8'h00, 8'h15});
    tbl.push_back('{1'b1, 1'b0, AW'(3),      8'hFF, 8'h15});
    tbl.push_back('{1'b0, 1'b1, AW'(3),      8'h00, 8'h3F});
    tbl.push_back('{1'b1, 1'b0, AW'(ND),     8'hFC, 8'h3F});
    tbl.push_back('{1'b0, 1'b1, AW'(ND),     8'h00, 8'h00});
    tbl.push_back('{1'b1, 1'b0, AW'(ND),     8'hFD, 8'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(ND),     8'h00, 8'h01});
    tbl.push_back('{1'b1, 1'b0, AW'(3),      8'h10, 8'h01});
    tbl.push_back('{1'b0, 1'b1, AW'(0),      8'h00, 8'h10});
    run_table("regs");
    idle(1);
    check("regs_disp", hex, exp_disp(1'b0));

    // Global enable off and back on
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h00);
    idle(1);
    check("disable_disp", hex, ALL_OFF);
    tbl.push_back('{1'b0, 1'b1, AW'(2), 8'h00, 8'h0A});
    run_table("disabled_keep");
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h01);
    check("enable_latency_disp", hex, ALL_OFF);
    idle(1);
    check("enable_disp", hex, exp_disp(1'b0));

    // Blink timing with exact period, then steady after blink_en clears
    bus_cycle(1'b1, 1'b0, AW'(0), 8'h23);
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h03);
    blink_run("blink", 3 * DIV);
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h01);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check($sformatf("steady_k%0d", k), hex, exp_disp(1'b0));
      check($sformatf("steady_d0_k%0d", k), hex[6:0], 7'b0110000);
    end

    // Reset for one cycle in the middle of a blink period
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h03);
    idle(DIV + 2);
    tbl.push_back('{1'b0, 1'b1, AW'(2), 8'h00, 8'h0A});
    run_table("pre_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("midblink_reset_disp", hex, ALL_OFF);
    check("midblink_reset_rdata", bus.oRead_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    load_reset_table();
    run_table("post_reset");
    check("post_reset_disp", hex, ALL_OFF);

    // Blink period restarts from zero after reset
    bus_cycle(1'b1, 1'b0, AW'(0), 8'h23);
    bus_cycle(1'b1, 1'b0, AW'(ND), 8'h03);
    blink_run("reblink", 2 * DIV + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_bank_control.md
HEX_BANK_CONTROL -- requirements
Module: hex_bank_control

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, giving the number of seven-segment digits driven (1..8).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, giving the clock cycles per blink half-period (>=2).
REQ-003 The block SHALL have local constant AW = clog2(NUM_DIGITS+1), the register address width.
REQ-004 iClk  in  1  single clock; all state changes on its rising edge.
REQ-005 iReset  in  1  synchronous, active-high reset, sampled on the rising edge of iClk.
REQ-006 iChip_select_n  in  1  active-low slave select.
REQ-007 iWrite_n  in  1  active-low write strobe, qualified by iChip_select_n.
REQ-008 iRead_n  in  1  active-low read strobe, qualified by iChip_select_n.
REQ-009 iAddress  in  AW  register index: 0..NUM_DIGITS-1 are digit registers; NUM_DIGITS is the control register.
REQ-010 iWrite_data  in  8  write data; digit register uses [3:0] value, [4] blank, [5] blink; control register uses [0] enable, [1] blink_en.
REQ-011 oRead_data  out  8  registered read data.
REQ-012 oHex_Display  out  7*NUM_DIGITS  segment outputs, digit k at bits [7k+6:7k], active-low (common-anode).

Function
REQ-013 A write SHALL occur on a cycle with iChip_select_n=0 and iWrite_n=0, updating the addressed register's defined bits at that edge; undefined bits SHALL be dropped.
REQ-014 Writes to addresses > NUM_DIGITS SHALL be ignored with no state change.
REQ-015 A read SHALL occur on a cycle with iChip_select_n=0, iRead_n=0 and iWrite_n=1; oRead_data SHALL present the addressed register, zero-extended, on the next edge (latency 1) and hold until the next read.
REQ-016 Reads of addresses > NUM_DIGITS SHALL return 8'h00.
REQ-017 Simultaneous read and write strobes SHALL be treated as a write only; oRead_data SHALL hold its value.
REQ-018 The value field SHALL decode to segments as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 A blink counter SHALL count 0..BLINK_DIV-1, wrapping to 0 and toggling blink_phase at BLINK_DIV-1; it SHALL run only while blink_en=1 and SHALL be held at 0 with blink_phase=0 while blink_en=0.
REQ-020 Digit k's output SHALL be 7'b1111111 when enable=0, or its blank=1, or (its blink=1 and blink_en=1 and blink_phase=1); otherwise it SHALL be the decoded value.
REQ-021 oHex_Display SHALL be registered: a write at edge N SHALL appear on the outputs after edge N+1 (latency 1).
REQ-022 A write clearing blink_en SHALL reset the counter and blink_phase at the same edge, so blinking digits show their value from the next output update onward.

Reset
REQ-023 During iReset=1: all digit registers SHALL become value=0, blank=1, blink=0; control SHALL become enable=1, blink_en=0; counter and blink_phase SHALL be 0.
REQ-024 During iReset=1: oHex_Display SHALL be all ones and oRead_data SHALL be 8'h00.
REQ-025 Reset SHALL take priority over any simultaneous write or read; an asserted mid-blink reset SHALL restart the blink period from 0.

Structure
REQ-026 Package hex_pkg SHALL hold SEG_BLANK (7'b1111111), the 16-entry segment table, and the digit/control bit-position constants.
REQ-027 A combinational sub-module hex_seg_decoder (4-bit in, 7-bit out) SHALL be instantiated once per digit.

Verification
REQ-028 Reset then read all addresses -> digit registers read 8'h10, control reads 8'h01, oHex_Display all ones.
REQ-029 Write addr 2 = 8'h0A -> after one further edge, digit 2 = 0001000 and all other digits stay 1111111; read addr 2 returns 8'h0A.
REQ-030 With BLINK_DIV=4, write digit 0 = 8'h23 and control = 8'h03 -> digit 0 alternates 0110000 / 1111111 every 4 cycles; writing control = 8'h01 shows a steady 0110000.
REQ-031 Write control = 8'h00 -> all digits 1111111 while registers keep their values; write 8'h01 -> prior values reappear one cycle later.
REQ-032 Write to addr NUM_DIGITS+1 and read it -> no state change, read 8'h00; simultaneous read+write to addr 1 -> write takes effect, oRead_data unchanged.
REQ-033 Assert iReset for one cycle mid-blink with digits loaded -> next cycle all outputs 1111111, registers at reset values, counter 0.
